// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles little-endian words from a byte
// stream, writes them to consecutive imem addresses, then releases the core reset.
module imem_loader #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW:0]   len,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_waddr,
   output logic [31:0]   imem_wdata,
   output logic          cpu_rst_n,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [31:0]   checksum
);

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      WRITE,
      RUN,
      ERR
   } state_e;

   localparam logic [AW:0] LenMax = (AW+1)'(DEPTH);

   state_e        state_q, state_d;
   logic [AW:0]   len_q;
   logic [AW:0]   word_cnt_q;
   logic [1:0]    byte_cnt_q;
   logic [23:0]   lanes_q;
   logic [AW-1:0] waddr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   checksum_q;
   logic          lenOk;
   logic          canStart;
   logic          accept;

   assign lenOk    = (len != '0) && (len <= LenMax);
   assign canStart = (state_q == IDLE) || (state_q == RUN) || (state_q == ERR);
   assign accept   = (state_q == RECV) && byte_valid && byte_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, RUN, ERR: begin
            if (start) begin
               state_d = lenOk ? RECV : ERR;
            end
         end
         RECV: begin
            if (accept && (byte_cnt_q == 2'd3)) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            state_d = ((word_cnt_q + (AW+1)'(1)) == len_q) ? RUN : RECV;
         end
         default: state_d = IDLE;
      endcase
   end

   // Lanes 0..2 are buffered; lane 3 arrives with the handshake that completes the word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q      <= '0;
         word_cnt_q <= '0;
         byte_cnt_q <= '0;
         lanes_q    <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         checksum_q <= '0;
      end else begin
         if (canStart && start && lenOk) begin
            len_q      <= len;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            checksum_q <= '0;
         end
         if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
               2'd0: lanes_q[7:0]   <= byte_data;
               2'd1: lanes_q[15:8]  <= byte_data;
               2'd2: lanes_q[23:16] <= byte_data;
               default: begin
                  waddr_q <= word_cnt_q[AW-1:0];
                  wdata_q <= {byte_data, lanes_q};
               end
            endcase
         end
         if (state_q == WRITE) begin
            checksum_q <= checksum_q ^ wdata_q;
            word_cnt_q <= word_cnt_q + (AW+1)'(1);
            byte_cnt_q <= '0;
         end
      end
   end

   // Status outputs are flops fed from the next state so they change cleanly on the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         busy       <= 1'b0;
         cpu_rst_n  <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         byte_ready <= (state_d == RECV);
         imem_we    <= (state_d == WRITE);
         busy       <= (state_d == RECV) || (state_d == WRITE);
         cpu_rst_n  <= (state_d == RUN);
         done       <= (state_d == RUN);
         err        <= (state_d == ERR);
      end
   end

   assign imem_waddr = waddr_q;
   assign imem_wdata = wdata_q;
   assign checksum   = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a byte-level model predicts each imem write,
// and a negedge monitor pops and compares whenever imem_we is seen.
module tb_imem_loader;

   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW:0]   len;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata;
   logic          cpu_rst_n;
   logic          busy;
   logic          done;
   logic          err;
   logic [31:0]   checksum;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t         expQ[$];
   logic [7:0]  imgBytes[$];
   logic [31:0] modelChk;
   int          vectors = 0;
   int          miscompares = 0;

   imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checkOutput(name, 32'(act), 32'(exp));
   endtask

   // Any write strobe must match the oldest predicted write; a strobe with nothing predicted is an error.
   always @(negedge clk) begin
      wr_t e;
      if (imem_we === 1'b1) begin
         if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected write: addr %0d data 0x%08h, none expected", imem_waddr, imem_wdata);
         end else begin
            e = expQ.pop_front();
            checkOutput("write address", 32'(imem_waddr), 32'(e.addr));
            checkOutput("write data", imem_wdata, e.data);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkResetValues(input string tag);
      checkBit({tag, " byte_ready"}, byte_ready, 1'b0);
      checkBit({tag, " imem_we"}, imem_we, 1'b0);
      checkOutput({tag, " imem_waddr"}, 32'(imem_waddr), 32'd0);
      checkOutput({tag, " imem_wdata"}, imem_wdata, 32'd0);
      checkBit({tag, " cpu_rst_n"}, cpu_rst_n, 1'b0);
      checkBit({tag, " busy"}, busy, 1'b0);
      checkBit({tag, " done"}, done, 1'b0);
      checkBit({tag, " err"}, err, 1'b0);
      checkOutput({tag, " checksum"}, checksum, 32'd0);
   endtask

   // All driving tasks start and end one time unit after a rising edge.
   task automatic pulseStart(input logic [AW:0] l);
      start = 1'b1;
      len   = l;
      @(posedge clk);
      #1;
      start = 1'b0;
      len   = (AW+1)'($urandom);
   endtask

   task automatic sendByte(input logic [7:0] b, input int gap);
      int t;
      byte_valid = 1'b0;
      repeat (gap) begin
         byte_data = 8'($urandom);
         @(posedge clk);
         #1;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      t = 0;
      @(negedge clk);
      while (byte_ready !== 1'b1 && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (t >= 50) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL byte handshake timeout: byte_ready %b, required 1", byte_ready);
      end
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
   endtask

   task automatic checkRun();
      @(negedge clk);
      checkBit("write cycle imem_we", imem_we, 1'b1);
      checkBit("write cycle cpu_rst_n", cpu_rst_n, 1'b0);
      @(negedge clk);
      checkBit("run cpu_rst_n", cpu_rst_n, 1'b1);
      checkBit("run done", done, 1'b1);
      checkBit("run busy", busy, 1'b0);
      checkBit("run byte_ready", byte_ready, 1'b0);
      checkOutput("run checksum", checksum, modelChk);
      checkOutput("pending writes", 32'(expQ.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Loads nWords from imgBytes; gap<0 means random stalls; midStart is the byte index after which a stray start is pulsed.
   task automatic applyStimulus(input int nWords, input int gap, input int midStart);
      logic [31:0] w;
      int          g;
      int          idx;
      modelChk = 32'd0;
      pulseStart(nWords[AW:0]);
      @(negedge clk);
      checkBit("load begin busy", busy, 1'b1);
      checkBit("load begin byte_ready", byte_ready, 1'b1);
      checkBit("load begin cpu_rst_n", cpu_rst_n, 1'b0);
      checkBit("load begin done", done, 1'b0);
      checkBit("load begin err", err, 1'b0);
      @(posedge clk);
      #1;
      for (int i = 0; i < nWords; i++) begin
         w = 32'(imgBytes[4*i]) + (32'(imgBytes[4*i+1]) * 256)
           + (32'(imgBytes[4*i+2]) * 65536) + (32'(imgBytes[4*i+3]) * 16777216);
         for (int k = 0; k < 4; k++) begin
            idx = 4*i + k;
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            if (k == 3) begin
               expQ.push_back('{addr: i[AW-1:0], data: w});
               modelChk = modelChk ^ w;
            end
            sendByte(imgBytes[idx], g);
            if (idx == midStart) begin
               pulseStart((AW+1)'($urandom_range(0, 63)));
            end
         end
      end
      checkRun();
   endtask

   task automatic randomImage(input int nWords);
      imgBytes.delete();
      for (int i = 0; i < 4*nWords; i++) begin
         imgBytes.push_back(8'($urandom));
      end
   endtask

   initial begin
      int n;
      rst_n      = 1'b0;
      start      = 1'b0;
      len        = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      checkResetValues("reset");
      rst_n = 1'b1;

      $display("[TB] basic two-word load");
      imgBytes = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
      applyStimulus(2, 0, -1);
      checkOutput("basic checksum constant", checksum, 32'h00900080);

      $display("[TB] same load with three idle cycles between bytes");
      applyStimulus(2, 3, -1);
      checkOutput("gapped checksum constant", checksum, 32'h00900080);

      $display("[TB] illegal lengths");
      pulseStart((AW+1)'(0));
      byte_valid = 1'b1;
      byte_data  = 8'hA5;
      @(negedge clk);
      checkBit("len0 err", err, 1'b1);
      checkBit("len0 byte_ready", byte_ready, 1'b0);
      checkBit("len0 cpu_rst_n", cpu_rst_n, 1'b0);
      checkBit("len0 done", done, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      byte_valid = 1'b0;
      pulseStart((AW+1)'(33));
      @(negedge clk);
      checkBit("len33 err", err, 1'b1);
      checkBit("len33 byte_ready", byte_ready, 1'b0);
      checkBit("len33 cpu_rst_n", cpu_rst_n, 1'b0);
      @(posedge clk);
      #1;
      imgBytes = '{8'hEF, 8'h01, 8'h80, 8'h00};
      applyStimulus(1, 0, -1);
      checkOutput("recovery checksum constant", checksum, 32'h008001EF);

      $display("[TB] full-depth load");
      randomImage(DEPTH);
      applyStimulus(DEPTH, -1, -1);
      repeat (4) @(posedge clk);
      #1;

      $display("[TB] reset in the middle of a load");
      randomImage(4);
      modelChk = 32'd0;
      pulseStart((AW+1)'(4));
      for (int k = 0; k < 6; k++) begin
         if (k == 3) begin
            expQ.push_back('{addr: '0, data: {imgBytes[3], imgBytes[2], imgBytes[1], imgBytes[0]}});
         end
         sendByte(imgBytes[k], int'($urandom_range(0, 2)));
      end
      rst_n = 1'b0;
      #2;
      checkResetValues("async reset");
      byte_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      byte_valid = 1'b0;
      checkOutput("writes after reset", 32'(expQ.size()), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkBit("post-reset cpu_rst_n", cpu_rst_n, 1'b0);
      checkBit("post-reset busy", busy, 1'b0);
      checkBit("post-reset byte_ready", byte_ready, 1'b0);
      @(posedge clk);
      #1;

      $display("[TB] reload from run and ignored start");
      randomImage(1);
      applyStimulus(1, 0, -1);
      randomImage(1);
      applyStimulus(1, 1, 1);

      $display("[TB] randomized loads");
      for (int r = 0; r < 8; r++) begin
         n = int'($urandom_range(1, 6));
         randomImage(n);
         applyStimulus(n, -1, int'($urandom_range(0, 4*n - 2)));
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("final pending writes", 32'(expQ.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
